// File: rtl/lcd_status_reader_if.sv
// Request/result and LCD pin bundle for the HD44780 read engine.
// The master side issues requests and models the panel; the slave side is the engine.
interface lcd_status_reader_if;
    logic       req;
    logic       rs_sel;
    logic       poll;
    logic       busy;
    logic       done;
    logic [7:0] rd_data;
    logic       bf;
    logic [6:0] ac;
    logic       timeout;
    logic       bus_owned;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_data_in;

    modport master (
        output req, rs_sel, poll, lcd_data_in,
        input  busy, done, rd_data, bf, ac, timeout, bus_owned, lcd_rs, lcd_rw, lcd_e
    );

    modport slave (
        input  req, rs_sel, poll, lcd_data_in,
        output busy, done, rd_data, bf, ac, timeout, bus_owned, lcd_rs, lcd_rw, lcd_e
    );
endinterface

// File: rtl/lcd_status_reader.sv
// HD44780 read-side bus engine: RW=1 reads of the BF/AC register or a DDRAM byte,
// with optional re-polling of the status register until the busy flag clears.
module lcd_status_reader #(
    parameter int T_AS      = 3,
    parameter int T_EH      = 12,
    parameter int T_EL      = 12,
    parameter int MAX_POLLS = 255
) (
    input  logic               clk,
    input  logic               reset,
    lcd_status_reader_if.slave bus
);
    localparam int T_MAX1 = (T_AS > T_EH) ? T_AS : T_EH;
    localparam int T_MAX  = (T_MAX1 > T_EL) ? T_MAX1 : T_EL;
    localparam int CNT_W  = $clog2(T_MAX + 1);
    localparam int PC_W   = $clog2(MAX_POLLS + 1);

    typedef enum logic [2:0] {IDLE, SETUP, EHIGH, ELOW, DONE} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [PC_W-1:0]  polls_q;
    logic             rs_q;
    logic             poll_q;
    logic             busy_q;
    logic             done_q;
    logic [7:0]       rd_data_q;
    logic             timeout_q;
    logic             lcd_rs_q;
    logic             lcd_rw_q;
    logic             lcd_e_q;

    // cnt_q holds the remaining cycles of the current phase minus one.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            polls_q   <= '0;
            rs_q      <= 1'b0;
            poll_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_data_q <= '0;
            timeout_q <= 1'b0;
            lcd_rs_q  <= 1'b0;
            lcd_rw_q  <= 1'b0;
            lcd_e_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req) begin
                        rs_q      <= bus.rs_sel;
                        poll_q    <= bus.poll & ~bus.rs_sel;
                        timeout_q <= 1'b0;
                        polls_q   <= PC_W'(1);
                        cnt_q     <= CNT_W'(T_AS - 1);
                        busy_q    <= 1'b1;
                        lcd_rw_q  <= 1'b1;
                        lcd_rs_q  <= bus.rs_sel;
                        state_q   <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_q == '0) begin
                        cnt_q   <= CNT_W'(T_EH - 1);
                        lcd_e_q <= 1'b1;
                        state_q <= EHIGH;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                EHIGH: begin
                    if (cnt_q == '0) begin
                        rd_data_q <= bus.lcd_data_in;
                        cnt_q     <= CNT_W'(T_EL - 1);
                        lcd_e_q   <= 1'b0;
                        state_q   <= ELOW;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ELOW: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else if (poll_q && rd_data_q[7] && (polls_q < PC_W'(MAX_POLLS))) begin
                        polls_q <= polls_q + PC_W'(1);
                        cnt_q   <= CNT_W'(T_AS - 1);
                        state_q <= SETUP;
                    end else begin
                        // Poll budget exhausted with the panel still busy.
                        if (poll_q && rd_data_q[7]) timeout_q <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q   <= 1'b0;
                    lcd_rw_q <= 1'b0;
                    lcd_rs_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    busy_q   <= 1'b0;
                    lcd_rw_q <= 1'b0;
                    lcd_rs_q <= 1'b0;
                    lcd_e_q  <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.bus_owned = busy_q;
    assign bus.done      = done_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.bf        = rd_data_q[7];
    assign bus.ac        = rd_data_q[6:0];
    assign bus.timeout   = timeout_q;
    assign bus.lcd_rs    = lcd_rs_q;
    assign bus.lcd_rw    = lcd_rw_q;
    assign bus.lcd_e     = lcd_e_q;
endmodule

// File: tb/tb_lcd_status_reader.sv
// Directed bench for lcd_status_reader with a small HD44780 read-side panel model.
module tb_lcd_status_reader;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    lcd_status_reader_if ifc ();

    lcd_status_reader #(.MAX_POLLS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    always #10 clk = ~clk;

    logic [7:0] resp [0:7];
    int         e_pulses, e_cycles, first_e, last_e, done_cnt, done1, done2, rsrw_bad;
    logic       rs_at_e, rw_at_e;
    logic [7:0] rd_log   [0:255];
    logic       busy_log [0:255];
    logic       e_log    [0:255];
    logic       rw_log   [0:255];
    logic       to_log   [0:255];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One transaction observed cycle by cycle; cycle 0 is the accept cycle.
    // The panel drives garbage for the first part of each E pulse, then the
    // real byte, and releases the bus (0x00) while E is low.
    task automatic run(input logic rs, input logic pl, input bit hold,
                       input int pulse_at, input int rst_at, input int ncyc);
        logic e_prev;
        logic rs_r, rw_r;
        int   in_pulse;
        e_pulses = 0; e_cycles = 0; first_e = -1; last_e = -1;
        done_cnt = 0; done1 = -1; done2 = -1; rsrw_bad = 0;
        rs_at_e = 1'b0; rw_at_e = 1'b0;
        e_prev = 1'b0; rs_r = 1'b0; rw_r = 1'b0; in_pulse = 0;
        @(negedge clk);
        ifc.req = 1'b1; ifc.rs_sel = rs; ifc.poll = pl;
        for (int t = 1; t <= ncyc; t++) begin
            @(negedge clk);
            if (ifc.lcd_e) begin
                if (!e_prev) begin
                    e_pulses++;
                    in_pulse = 0;
                    rs_r = ifc.lcd_rs; rw_r = ifc.lcd_rw;
                    if (e_pulses == 1) begin
                        first_e = t; rs_at_e = ifc.lcd_rs; rw_at_e = ifc.lcd_rw;
                    end
                end else if (ifc.lcd_rs !== rs_r || ifc.lcd_rw !== rw_r) begin
                    rsrw_bad++;
                end
                in_pulse++;
                ifc.lcd_data_in = (in_pulse >= 8) ? resp[(e_pulses - 1) % 8] : 8'hEE;
                e_cycles++;
                last_e = t;
            end else begin
                ifc.lcd_data_in = 8'h00;
            end
            e_prev = ifc.lcd_e;
            if (ifc.done) begin
                done_cnt++;
                if (done_cnt == 1) done1 = t; else done2 = t;
            end
            rd_log[t] = ifc.rd_data; busy_log[t] = ifc.busy; e_log[t] = ifc.lcd_e;
            rw_log[t] = ifc.lcd_rw;  to_log[t] = ifc.timeout;
            ifc.req = (hold && done_cnt < 2) || (t == pulse_at);
            reset   = (t == rst_at);
        end
        ifc.req = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        ifc.req = 1'b0; ifc.rs_sel = 1'b0; ifc.poll = 1'b0; ifc.lcd_data_in = 8'h00;
        for (int i = 0; i < 8; i++) resp[i] = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_outputs",
              {ifc.busy, ifc.done, ifc.rd_data, ifc.bf, ifc.ac, ifc.timeout,
               ifc.bus_owned, ifc.lcd_rs, ifc.lcd_rw, ifc.lcd_e}, 32'h0);
        check("rst_busy", ifc.busy, 1'b0);
        reset = 1'b0;

        // Single data read
        resp[0] = 8'h41;
        run(1'b1, 1'b0, 1'b0, -1, -1, 40);
        check("t1_rw_setup", {rw_log[1], busy_log[1], e_log[3]}, 3'b110);
        check("t1_rsrw_at_e", {rs_at_e, rw_at_e}, 2'b11);
        check("t1_e_first", first_e, 4);
        check("t1_e_last", last_e, 15);
        check("t1_e_cycles", e_cycles, 12);
        check("t1_rd_timing", {rd_log[15], rd_log[16]}, {8'h00, 8'h41});
        check("t1_done_cyc", done1, 28);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_rd_data", ifc.rd_data, 8'h41);
        check("t1_idle_after", {busy_log[29], ifc.bus_owned, ifc.lcd_rw}, 3'b000);

        // Status read, no poll
        resp[0] = 8'h8A;
        run(1'b0, 1'b0, 1'b0, -1, -1, 40);
        check("t2_done_cyc", done1, 28);
        check("t2_bf_ac", {ifc.bf, ifc.ac}, {1'b1, 7'h0A});
        check("t2_timeout", ifc.timeout, 1'b0);
        check("t2_pulses", e_pulses, 1);

        // Poll until BF clears on the third read
        resp[0] = 8'h85; resp[1] = 8'h85; resp[2] = 8'h05;
        run(1'b0, 1'b1, 1'b0, -1, -1, 95);
        check("t3_pulses", e_pulses, 3);
        check("t3_done_cyc", done1, 82);
        check("t3_bf_ac", {ifc.bf, ifc.ac}, {1'b0, 7'h05});
        check("t3_timeout", ifc.timeout, 1'b0);

        // Poll timeout with MAX_POLLS=4
        for (int i = 0; i < 8; i++) resp[i] = 8'h80;
        run(1'b0, 1'b1, 1'b0, -1, -1, 120);
        check("t4_pulses", e_pulses, 4);
        check("t4_done_cyc", done1, 109);
        check("t4_timeout_at_done", to_log[109], 1'b1);
        check("t4_timeout_held", ifc.timeout, 1'b1);

        // Next accept clears timeout; poll ignored for data reads
        resp[0] = 8'hB3;
        run(1'b1, 1'b1, 1'b0, -1, -1, 40);
        check("t5_timeout_clr", to_log[1], 1'b0);
        check("t5_data_no_poll", {e_pulses[7:0], ifc.rd_data}, {8'd1, 8'hB3});
        check("t5_timeout_end", ifc.timeout, 1'b0);

        // Reset during EHIGH
        resp[0] = 8'h77;
        run(1'b0, 1'b0, 1'b0, -1, 8, 40);
        check("t6_e_before", e_log[8], 1'b1);
        check("t6_after_rst", {e_log[9], busy_log[9]}, 2'b00);
        check("t6_rd_cleared", rd_log[9], 8'h00);
        check("t6_no_done", done_cnt, 0);

        // Stray requests mid-read and during DONE
        resp[0] = 8'h12;
        run(1'b0, 1'b0, 1'b0, 10, -1, 60);
        check("t7_done_cnt", done_cnt, 1);
        check("t7_done_cyc", done1, 28);
        run(1'b0, 1'b0, 1'b0, 28, -1, 60);
        check("t7b_done_cnt", done_cnt, 1);
        check("t7b_idle", busy_log[30], 1'b0);

        // Back-to-back with req held
        resp[0] = 8'h21; resp[1] = 8'h22;
        run(1'b1, 1'b0, 1'b1, -1, -1, 70);
        check("t8_done1", done1, 28);
        check("t8_done2", done2, 57);
        check("t8_idle_gap", {busy_log[29], busy_log[30]}, 2'b01);
        check("t8_pulses", e_pulses, 2);
        check("t8_rsrw_stable", rsrw_bad, 0);
        check("t8_rd_data", ifc.rd_data, 8'h22);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
